// File: rtl/if_id_skid_buffer_pkg.sv
// asip_pipeline_pkg: shared IF/ID types and constants for fetch and decode.
package asip_pipeline_pkg;

   localparam int unsigned IF_ID_WIDTH = 32;
   localparam logic [IF_ID_WIDTH-1:0] IF_ID_NOP_INSTR = 32'h0;

   typedef struct packed {
      logic [IF_ID_WIDTH-1:0] pc;
      logic [IF_ID_WIDTH-1:0] instr;
   } if_id_entry_t;

endpackage

// File: rtl/if_id_skid_buffer_if.sv
// if_id_skid_buffer_if: fetch-side and decode-side handshake bundle of the IF/ID buffer.
interface if_id_skid_buffer_if
   import asip_pipeline_pkg::*;
#(
   parameter int unsigned WIDTH = IF_ID_WIDTH
);

   logic [WIDTH-1:0] in_pc;
   logic [WIDTH-1:0] in_instr;
   logic             in_valid;
   logic             in_ready;
   logic             flush;
   logic [WIDTH-1:0] out_pc;
   logic [WIDTH-1:0] out_instr;
   logic             out_valid;
   logic             out_ready;

   modport master (
      output in_pc, in_instr, in_valid, flush, out_ready,
      input  in_ready, out_pc, out_instr, out_valid
   );

   modport slave (
      input  in_pc, in_instr, in_valid, flush, out_ready,
      output in_ready, out_pc, out_instr, out_valid
   );

endinterface

// File: rtl/if_id_skid_buffer.sv
// if_id_skid_buffer: two-entry in-order IF/ID buffer with backpressure, flush and NOP bubble.
module if_id_skid_buffer
   import asip_pipeline_pkg::*;
#(
   parameter int unsigned      WIDTH     = IF_ID_WIDTH,
   parameter logic [WIDTH-1:0] NOP_INSTR = IF_ID_NOP_INSTR
) (
   input  logic               clk,
   input  logic               reset,
   if_id_skid_buffer_if.slave bus
);

   if_id_entry_t r_entry [2];
   logic [1:0]   r_count;
   logic         r_head;

   if_id_entry_t w_head_entry;
   logic         w_push;
   logic         w_pop;
   logic         w_wr;

   assign w_push = bus.in_valid & bus.in_ready;
   assign w_pop  = bus.out_valid & bus.out_ready;
   // With one item held, the new one goes behind the head; otherwise into the head slot.
   assign w_wr   = r_head ^ (r_count == 2'd1);

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_entry[0] <= '{pc: '0, instr: NOP_INSTR};
         r_entry[1] <= '{pc: '0, instr: NOP_INSTR};
         r_count    <= 2'd0;
         r_head     <= 1'b0;
      end else if (bus.flush) begin
         r_count <= 2'd0;
         r_head  <= 1'b0;
      end else begin
         if (w_push) r_entry[w_wr] <= '{pc: bus.in_pc, instr: bus.in_instr};
         if (w_pop) r_head <= ~r_head;
         r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      end
   end

   always_comb begin
      w_head_entry  = r_entry[r_head];
      bus.in_ready  = (r_count != 2'd2) & reset;
      bus.out_valid = (r_count != 2'd0);
      bus.out_pc    = bus.out_valid ? w_head_entry.pc : '0;
      bus.out_instr = bus.out_valid ? w_head_entry.instr : NOP_INSTR;
   end

endmodule
